// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, instruction field offsets and issue FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int INSTR_W = 12;
  localparam int LDI_BIT = 11;
  localparam int OP_LSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 2;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;
  localparam logic [2:0] OP_NOTB = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : Register file, two async read ports, one sync write port
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile #(
  parameter int DATA_W = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issues instructions to an external ALU, writes back and reports
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int REG_AW = 2,
  parameter int OP_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [INSTR_W-1:0]   instr,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [OP_W-1:0]      alu_op,
  input  logic [DATA_W-1:0]    alu_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic [REG_AW-1:0]    res_rd,
  output logic                 res_zero,
  output logic                 res_illegal
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [REG_AW-1:0]   rs1_q, rs1_d;
  logic [REG_AW-1:0]   rs2_q, rs2_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [REG_AW-1:0]   res_rd_q, res_rd_d;
  logic                res_zero_q, res_zero_d;
  logic                res_illegal_q, res_illegal_d;

  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   rf_a, rf_b;
  logic [DATA_W-1:0]   imm;

  assign imm = instr[IMM_LSB +: DATA_W];

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (rs1_q),
    .ra_data (rf_a),
    .rb_addr (rs2_q),
    .rb_data (rf_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rd_d          = rd_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    res_data_d    = res_data_q;
    res_rd_d      = res_rd_q;
    res_zero_d    = res_zero_q;
    res_illegal_d = res_illegal_q;
    rf_we         = 1'b0;
    rf_waddr      = rd_q;
    rf_wdata      = alu_result;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d  = instr[OP_LSB +: OP_W];
          rd_d  = instr[RD_LSB +: REG_AW];
          rs1_d = instr[RS1_LSB +: REG_AW];
          rs2_d = instr[RS2_LSB +: REG_AW];
          if (instr[LDI_BIT]) begin
            // Immediate load bypasses the ALU and retires at the accept edge
            rf_we         = 1'b1;
            rf_waddr      = instr[RD_LSB +: REG_AW];
            rf_wdata      = imm;
            res_data_d    = imm;
            res_rd_d      = instr[RD_LSB +: REG_AW];
            res_zero_d    = (imm == '0);
            res_illegal_d = 1'b0;
            state_d       = ST_RESP;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        rf_we         = 1'b1;
        res_data_d    = alu_result;
        res_rd_d      = rd_q;
        res_zero_d    = (alu_result == '0);
        res_illegal_d = (op_q == OP_ILL);
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      res_zero_q    <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      res_data_q    <= res_data_d;
      res_rd_q      <= res_rd_d;
      res_zero_q    <= res_zero_d;
      res_illegal_q <= res_illegal_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_RESP);
  assign alu_a       = (state_q == ST_EXEC) ? rf_a : '0;
  assign alu_b       = (state_q == ST_EXEC) ? rf_b : '0;
  assign alu_op      = (state_q == ST_EXEC) ? op_q : '0;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_zero    = res_zero_q;
  assign res_illegal = res_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with an external ALU
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr;
  logic [3:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        res_valid, res_ready;
  logic [3:0]  res_data;
  logic [1:0]  res_rd;
  logic        res_zero, res_illegal;

  int n_checks = 0;
  int n_fail   = 0;
  int model_regs [4];

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .res_zero    (res_zero),
    .res_illegal (res_illegal)
  );

  // External combinational ALU
  always_comb begin
    alu_result = 4'h0;
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_NOTA: alu_result = ~alu_a;
      OP_NOTB: alu_result = ~alu_b;
      default: alu_result = 4'h0;
    endcase
  end

  typedef struct {
    logic [11:0] ins;
    int          hold;
    logic [3:0]  e_data;
    logic        e_zero;
    logic        e_ill;
  } vec_t;

  function automatic logic [11:0] mk_alu(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
    return {1'b0, op, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [11:0] mk_ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {1'b1, 3'b000, rd, 2'b00, imm};
  endfunction

  // Reference: plain modulo-16 integer arithmetic
  function automatic int ref_result(input logic [2:0] op, input int a, input int b);
    case (op)
      3'd1:    return (a + b) % 16;
      3'd2:    return (a - b + 16) % 16;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return 15 - a;
      3'd6:    return 15 - b;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issues one instruction starting at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic do_instr(input logic [11:0] ins, input int hold,
                          input logic [3:0] e_data, input logic e_zero, input logic e_ill);
    logic       is_ldi;
    logic [1:0] rd, rs1, rs2;
    is_ldi = ins[11];
    rd     = ins[7:6];
    rs1    = ins[5:4];
    rs2    = ins[3:2];
    chk("instr_ready_idle", instr_ready, 1);
    chk("res_valid_idle", res_valid, 0);
    instr_valid = 1'b1;
    instr       = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    if (!is_ldi) begin
      chk("exec_instr_ready", instr_ready, 0);
      chk("exec_res_valid", res_valid, 0);
      chk("exec_alu_a", alu_a, model_regs[rs1]);
      chk("exec_alu_b", alu_b, model_regs[rs2]);
      chk("exec_alu_op", alu_op, ins[10:8]);
      @(negedge clk);
    end
    chk("resp_valid", res_valid, 1);
    chk("resp_instr_ready", instr_ready, 0);
    chk("resp_data", res_data, e_data);
    chk("resp_rd", res_rd, rd);
    chk("resp_zero", res_zero, e_zero);
    chk("resp_illegal", res_illegal, e_ill);
    chk("resp_alu_a_idle", alu_a, 0);
    model_regs[rd] = e_data;
    // A competing instruction stays offered while the response is pending
    for (int h = 0; h < hold; h++) begin
      res_ready   = 1'b0;
      instr_valid = 1'b1;
      instr       = mk_ldi(2'($urandom_range(3)), 4'($urandom_range(15)));
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, e_data);
      chk("hold_instr_ready", instr_ready, 0);
    end
    res_ready   = 1'b1;
    instr_valid = 1'b1;
    instr       = mk_ldi(2'($urandom_range(3)), 4'($urandom_range(15)));
    @(negedge clk);
    res_ready   = 1'b0;
    instr_valid = 1'b0;
    chk("done_valid", res_valid, 0);
    chk("done_instr_ready", instr_ready, 1);
  endtask

  vec_t vecs [8];

  initial begin
    int         r;
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [3:0] imm;

    vecs[0] = '{mk_ldi(2'd0, 4'd3),               0, 4'h3, 1'b0, 1'b0};
    vecs[1] = '{mk_ldi(2'd1, 4'd1),               0, 4'h1, 1'b0, 1'b0};
    vecs[2] = '{mk_alu(OP_ADD, 2'd2, 2'd0, 2'd1), 0, 4'h4, 1'b0, 1'b0};
    vecs[3] = '{mk_alu(OP_SUB, 2'd3, 2'd1, 2'd0), 1, 4'hE, 1'b0, 1'b0};
    vecs[4] = '{mk_alu(OP_CLR, 2'd3, 2'd3, 2'd3), 0, 4'h0, 1'b1, 1'b0};
    vecs[5] = '{mk_alu(OP_NOTA, 2'd0, 2'd0, 2'd0), 5, 4'hC, 1'b0, 1'b0};
    vecs[6] = '{mk_alu(OP_ILL, 2'd1, 2'd2, 2'd2), 0, 4'h0, 1'b1, 1'b1};
    vecs[7] = '{mk_alu(OP_OR, 2'd2, 2'd1, 2'd1),  0, 4'h0, 1'b1, 1'b0};

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    res_ready   = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_rd", res_rd, 0);
    chk("rst_res_zero", res_zero, 0);
    chk("rst_res_illegal", res_illegal, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);

    for (int v = 0; v < 8; v++) begin
      do_instr(vecs[v].ins, vecs[v].hold, vecs[v].e_data, vecs[v].e_zero, vecs[v].e_ill);
    end

    for (int n = 0; n < 150; n++) begin
      rd  = 2'($urandom_range(3));
      rs1 = 2'($urandom_range(3));
      rs2 = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) begin
        imm = 4'($urandom_range(15));
        do_instr(mk_ldi(rd, imm), $urandom_range(3), imm, imm == 4'h0, 1'b0);
      end else begin
        op = 3'($urandom_range(7));
        r  = ref_result(op, model_regs[rs1], model_regs[rs2]);
        do_instr(mk_alu(op, rd, rs1, rs2), $urandom_range(3), 4'(r), r == 0, op == 3'd7);
      end
    end

    // Reset while an ADD sits in EXEC: no writeback, everything cleared
    for (int i = 0; i < 4; i++) do_instr(mk_ldi(2'(i), 4'(i + 5)), 0, 4'(i + 5), 1'b0, 1'b0);
    instr_valid = 1'b1;
    instr       = mk_alu(OP_ADD, 2'd2, 2'd0, 2'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("pre_rst_exec_alu_a", alu_a, 4'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_instr_ready", instr_ready, 1);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_data", res_data, 0);
    chk("midrst_alu_a", alu_a, 0);
    for (int i = 0; i < 4; i++) model_regs[i] = 0;
    for (int i = 0; i < 4; i++) begin
      do_instr(mk_alu(OP_NOTA, 2'(i), 2'(i), 2'(i)), 0, 4'hF, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
